ram_fifo_ctrl: RTL
==================

# ram_fifo_ctrl

Single-clock first-word-fall-through FIFO controller that sequences a `simple_dp_ram` instance as its storage. It turns the RAM's raw write port and one-cycle-latency registered read port into valid/ready streams on both sides. It tracks occupancy and prefetches so that the RAM's read register acts as the FIFO output stage. It is the standard buffering block for CBB stream paths.

## Interface
- `DATA_WIDTH`, 32, payload width.
- `ADDR_WIDTH`, 4, RAM address width; RAM depth `DEPTH = 1<<ADDR_WIDTH`; legal range ≥ 2.
- `clk`  in  1  single clock for all logic and both RAM ports.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `clr`  in  1  synchronous flush.
- `s_valid`  in  1  write beat offered.
- `s_ready`  out  1  write beat accepted when `s_valid & s_ready`.
- `s_data`  in  DATA_WIDTH  write payload.
- `m_valid`  out  1  output beat present.
- `m_ready`  in  1  consumer takes beat when `m_valid & m_ready`.
- `m_data`  out  DATA_WIDTH  output payload, driven directly by the RAM read register.
- `level`  out  ADDR_WIDTH+1  total occupancy. Present only with `RAM_FIFO_LEVEL_EN`.

## Operation
- State:
  - `wr_ptr` and `rd_ptr` are ADDR_WIDTH-bit and wrap naturally at DEPTH.
  - `ram_cnt` is ADDR_WIDTH+1 bits and counts entries written but not yet read out of the RAM.
  - The `m_valid` flop marks the output stage as full.
- Capacity is DEPTH+1: DEPTH entries in the RAM plus one in the output register.
- Write:
  - `s_ready = (ram_cnt != DEPTH)`.
  - On an accepted beat, the RAM is written at `wr_ptr` and `wr_ptr` increments.
- Read issue: `rd_en = (ram_cnt != 0) & (~m_valid | m_ready) & ~clr`.
  - When `rd_en` is high, drive RAM `enb=1` with `addrb=rd_ptr` and increment `rd_ptr`.
- `m_valid` next value:
  - 1 if `rd_en`;
  - otherwise 0 if `m_ready`;
  - otherwise held.
- `ram_cnt` next value: `ram_cnt + wr_acc - rd_en`, where `wr_acc = s_valid & s_ready`. A simultaneous write and read leaves the count unchanged.
- No read-during-write hazard exists: `rd_en` requires `ram_cnt != 0`, so the slot being written is never the one being read.
- `m_data` is held stable while `m_valid & ~m_ready`, because the RAM read register only updates on `enb`. `m_data` is don't-care while `m_valid=0`.
- `clr`:
  - At the next edge, pointers, `ram_cnt` and `m_valid` go to 0.
  - A beat offered in the same cycle is dropped even if `s_ready` was 1.
  - `clr` overrides all other updates.
- Reset (`rst_n` low) clears the same state immediately, mid-operation included. RAM contents are not cleared.

## Timing
- Reset values:
  - `s_ready=1`, `m_valid=0`, `level=0`.
  - `m_data` is undefined until the first valid beat.
- Latency, empty FIFO: a beat accepted at edge E0 is visible with `m_valid=1` after edge E1, i.e. 2 cycles. There is no combinational path from `s_*` to `m_*`.
- Throughput: one beat per cycle sustained in and out once primed.
- `s_ready` depends on registered state only. `m_valid` is a flop. `m_ready` reaches the RAM `enb` combinationally.
- Full FIFO (`ram_cnt=DEPTH`, `m_valid=1`) with `m_ready=1`:
  - `s_ready` stays 0 this cycle.
  - `s_ready` rises the next cycle.

## Configuration
- `RAM_FIFO_LEVEL_EN`, defined: port `level = ram_cnt + m_valid` is a combinational output, range 0..DEPTH+1.
- Undefined: the port and its adder are absent. All other behaviour is identical.

## Structure
- No package. DEPTH is a local constant.
- `RAM_FIFO_LEVEL_EN` lives in the shared CBB define header.
- One sub-module: `simple_dp_ram`, with DATA_WIDTH and ADDR_WIDTH passed through.
  - Port a: `clka=clk`, `ena=wea=wr_acc`.
  - Port b: `clkb=clk`, `enb=rd_en`.
- Controller logic is the pointers, counter and `m_valid` flop.

## Test plan
All scenarios use ADDR_WIDTH=2, so DEPTH=4 and capacity is 5.
- Reset, then single write of 0xA5, `m_ready=1`:
  - `m_valid` rises 2 cycles after acceptance with `m_data=0xA5`.
  - `level` goes 0→1→1→0.
- `m_ready=0`, write 0x1..0x6 back-to-back:
  - 5 beats are accepted.
  - `s_ready` drops after the 5th.
  - `level=5`.
  - `m_data=0x1` is held.
- From full, `m_ready=1` with continuous writes:
  - Output order is 0x1,0x2,… with no gaps.
  - `s_ready` reasserts one cycle after the first pop.
- Randomized `s_valid`/`m_ready` over 1000 beats: output sequence equals input sequence, and `ram_cnt` never exceeds 4.
- `clr` asserted while holding 3 beats, together with a new write 0x77:
  - Next cycle `m_valid=0`, `level=0`, `s_ready=1`.
  - 0x77 never appears.
- `rst_n` pulsed low mid-burst: `m_valid` drops immediately. After release, a write of 0x3C is the first output.

Source files
------------

// File: rtl/simple_dp_ram.sv
// Simple dual-port RAM: write port a, one-cycle registered read port b.
// Contents are never reset; the read register only updates when enb is high.
module simple_dp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clka,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  clkb,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_doutb;

    always_ff @(posedge clka) begin
        if (ena && wea) begin
            r_mem[addra] <= dina;
        end
    end

    always_ff @(posedge clkb) begin
        if (enb) begin
            r_doutb <= r_mem[addrb];
        end
    end

    assign doutb = r_doutb;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO around simple_dp_ram; the RAM read register is the output stage.
// Optional occupancy port enabled by defining RAM_FIFO_LEVEL_EN.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef RAM_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_cnt;
    logic                  r_m_valid;

    logic                  w_wr_acc;
    logic                  w_rd_en;
    logic                  w_s_ready;
    logic [ADDR_WIDTH:0]   w_cnt_inc;
    logic [ADDR_WIDTH:0]   w_cnt_dec;

    assign w_s_ready = (r_ram_cnt != CNT_FULL);
    assign w_wr_acc  = s_valid & w_s_ready;
    // Refill the output register whenever it is empty or being drained this cycle.
    assign w_rd_en   = (r_ram_cnt != '0) & (~r_m_valid | m_ready) & ~clr;

    assign w_cnt_inc = {{ADDR_WIDTH{1'b0}}, w_wr_acc};
    assign w_cnt_dec = {{ADDR_WIDTH{1'b0}}, w_rd_en};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
            r_m_valid <= 1'b0;
        end else if (clr) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
            r_m_valid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_ram_cnt <= r_ram_cnt + w_cnt_inc - w_cnt_dec;
            if (w_rd_en) begin
                r_m_valid <= 1'b1;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    simple_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clka  (clk),
        .ena   (w_wr_acc),
        .wea   (w_wr_acc),
        .addra (r_wr_ptr),
        .dina  (s_data),
        .clkb  (clk),
        .enb   (w_rd_en),
        .addrb (r_rd_ptr),
        .doutb (m_data)
    );

    assign s_ready = w_s_ready;
    assign m_valid = r_m_valid;

`ifdef RAM_FIFO_LEVEL_EN
    assign level = r_ram_cnt + {{ADDR_WIDTH{1'b0}}, r_m_valid};
`endif

endmodule
